// File: rtl/cache_arbiter_pkg.sv
// Shared types and width defaults for the cache-to-memory arbiter.
// Consumers: cache_arbiter_if, arb_select, cache_arbiter.
package arbiter_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and physical-memory line-transfer signals.
// Handshake: a requester holds its read/write level until it sees its own *_resp
// for exactly one cycle; *_rdata is only meaningful in that cycle.
interface cache_arbiter_if #(
  parameter int LINE_W = arbiter_types::LINE_W,
  parameter int ADDR_W = arbiter_types::ADDR_W
);

  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side.
  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // Caches plus memory, as seen from outside the arbiter.
  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_arbiter_select.sv
// Combinational grant picker. With CACHE_ARB_ROUND_ROBIN_EN a tie goes to the
// requester not granted last; otherwise the dcache always wins a tie.
module arb_select
  import arbiter_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = GRANT_D;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_req) begin
      grant = GRANT_I;
    end
`else
    if (i_req && !d_req) begin
      grant = GRANT_I;
    end
`endif
  end

`ifndef CACHE_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between icache and dcache.
// Optional round-robin tie breaking is enabled by CACHE_ARB_ROUND_ROBIN_EN.
module cache_arbiter #(
  parameter int LINE_W = arbiter_types::LINE_W,
  parameter int ADDR_W = arbiter_types::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cache_arbiter_if.slave            bus,
  output arbiter_types::arb_state_t state
);

  import arbiter_types::*;

  arb_state_t        state_q, state_d;
  logic              load, done;
  logic              i_req, d_req;
  logic              grant_valid;
  arb_grant_t        grant, last_grant;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_resp, d_resp;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  arb_select u_select (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_grant_t last_grant_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_I;
    end else if (load) begin
      last_grant_q <= grant;
    end
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_I;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pmem_resp only matters while serving; the response goes to the owner alone.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = (grant == GRANT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          i_resp  = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          d_resp  = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read+write together from the dcache is resolved as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      if (grant == GRANT_D) begin
        read_q  <= ~bus.d_pmem_write;
        write_q <= bus.d_pmem_write;
        addr_q  <= bus.d_pmem_address;
        wdata_q <= bus.d_pmem_wdata;
      end else begin
        read_q  <= 1'b1;
        write_q <= 1'b0;
        addr_q  <= bus.i_pmem_address;
        wdata_q <= '0;
      end
    end else if (done) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_resp  = i_resp;
  assign bus.d_pmem_resp  = d_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign state            = state_q;

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.d_pmem_read && bus.d_pmem_write));
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single requesters, ties, fairness, reset, stray/dropped.
// Expected grant order in the fairness run follows CACHE_ARB_ROUND_ROBIN_EN.
module tb_cache_arbiter;
  import arbiter_types::*;

  logic       clk;
  logic       rst_n;
  arb_state_t state;
  int         checks = 0;
  int         errors = 0;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [255:0] line_a5, line_c3, line_wd;
  arb_grant_t   fair_exp [4];

  initial begin
    line_a5 = {32{8'hA5}};
    line_c3 = {32{8'hC3}};
    line_wd = {8{32'h1234_5678}};
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    fair_exp = '{GRANT_D, GRANT_I, GRANT_D, GRANT_I};
`else
    fair_exp = '{GRANT_D, GRANT_D, GRANT_D, GRANT_D};
`endif

    rst_n              = 1'b0;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;

    // Reset values
    #2;
    chk("rst_read",  bus.pmem_read, 0);
    chk("rst_write", bus.pmem_write, 0);
    chk("rst_addr",  bus.pmem_address, 0);
    chk("rst_wdata", bus.pmem_wdata, 0);
    chk("rst_iresp", bus.i_pmem_resp, 0);
    chk("rst_dresp", bus.d_pmem_resp, 0);
    chk("rst_state", state, IDLE);
    step();
    rst_n = 1'b1;

    // icache read alone, memory replies 3 cycles after pmem_read
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0060; #1;
    chk("t1_c0_read", bus.pmem_read, 0);
    step();
    chk("t1_c1_read",  bus.pmem_read, 1);
    chk("t1_c1_addr",  bus.pmem_address, 32'h60);
    chk("t1_c1_state", state, SERVE_I);
    step();
    chk("t1_c2_iresp", bus.i_pmem_resp, 0);
    step();
    chk("t1_c3_iresp", bus.i_pmem_resp, 0);
    chk("t1_c3_addr",  bus.pmem_address, 32'h60);
    step();
    bus.pmem_resp = 1'b1; bus.pmem_rdata = line_a5; #1;
    chk("t1_c4_iresp",  bus.i_pmem_resp, 1);
    chk("t1_c4_irdata", bus.i_pmem_rdata, line_a5);
    chk("t1_c4_dresp",  bus.d_pmem_resp, 0);
    step();
    bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; #1;
    chk("t1_c5_iresp", bus.i_pmem_resp, 0);
    chk("t1_c5_read",  bus.pmem_read, 0);
    chk("t1_c5_state", state, IDLE);

    // dcache writeback alone
    step();
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_1000; bus.d_pmem_wdata = line_wd;
    step();
    chk("t2_c1_write", bus.pmem_write, 1);
    chk("t2_c1_read",  bus.pmem_read, 0);
    chk("t2_c1_addr",  bus.pmem_address, 32'h1000);
    chk("t2_c1_wdata", bus.pmem_wdata, line_wd);
    chk("t2_c1_state", state, SERVE_D);
    step();
    chk("t2_c2_write", bus.pmem_write, 1);
    chk("t2_c2_addr",  bus.pmem_address, 32'h1000);
    chk("t2_c2_wdata", bus.pmem_wdata, line_wd);
    step();
    bus.pmem_resp = 1'b1; #1;
    chk("t2_c3_dresp", bus.d_pmem_resp, 1);
    chk("t2_c3_iresp", bus.i_pmem_resp, 0);
    step();
    bus.pmem_resp = 1'b0; bus.d_pmem_write = 1'b0; #1;
    chk("t2_c4_write", bus.pmem_write, 0);
    chk("t2_c4_state", state, IDLE);

    // Simultaneous requests: dcache first, icache 2 cycles after d_pmem_resp
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0200;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0300;
    step();
    chk("t3_c1_state", state, SERVE_D);
    chk("t3_c1_addr",  bus.pmem_address, 32'h300);
    chk("t3_c1_read",  bus.pmem_read, 1);
    step();
    bus.pmem_resp = 1'b1; bus.pmem_rdata = line_c3; #1;
    chk("t3_c2_dresp",  bus.d_pmem_resp, 1);
    chk("t3_c2_drdata", bus.d_pmem_rdata, line_c3);
    chk("t3_c2_iresp",  bus.i_pmem_resp, 0);
    step();
    bus.pmem_resp = 1'b0; bus.d_pmem_read = 1'b0; #1;
    chk("t3_c3_state", state, IDLE);
    chk("t3_c3_read",  bus.pmem_read, 0);
    step();
    chk("t3_c4_state", state, SERVE_I);
    chk("t3_c4_read",  bus.pmem_read, 1);
    chk("t3_c4_addr",  bus.pmem_address, 32'h200);
    step();
    bus.pmem_resp = 1'b1; #1;
    chk("t3_c5_iresp", bus.i_pmem_resp, 1);
    chk("t3_c5_dresp", bus.d_pmem_resp, 0);
    step();
    bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; #1;
    chk("t3_c6_state", state, IDLE);

    // Fairness: both hold requests across 4 minimum-length transactions
    step();
    bus.i_pmem_read = 1'b1; bus.d_pmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.pmem_resp = 1'b1; #1;
      chk("t4_grant_state", state, (fair_exp[k] == GRANT_D) ? SERVE_D : SERVE_I);
      chk("t4_dresp", bus.d_pmem_resp, (fair_exp[k] == GRANT_D) ? 1'b1 : 1'b0);
      chk("t4_iresp", bus.i_pmem_resp, (fair_exp[k] == GRANT_I) ? 1'b1 : 1'b0);
      step();
      bus.pmem_resp = 1'b0; #1;
      chk("t4_turn_state", state, IDLE);
    end
    bus.i_pmem_read = 1'b0; bus.d_pmem_read = 1'b0;
    step();
    chk("t4_end_state", state, IDLE);

    // Reset two cycles into SERVE_D, with a response arriving at the same time
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0400;
    step();
    chk("t5_c1_state", state, SERVE_D);
    step();
    chk("t5_c2_read", bus.pmem_read, 1);
    rst_n = 1'b0; bus.pmem_resp = 1'b1; #1;
    chk("t5_rst_read",  bus.pmem_read, 0);
    chk("t5_rst_write", bus.pmem_write, 0);
    chk("t5_rst_dresp", bus.d_pmem_resp, 0);
    chk("t5_rst_iresp", bus.i_pmem_resp, 0);
    chk("t5_rst_state", state, IDLE);
    step();
    rst_n = 1'b1; bus.pmem_resp = 1'b0; bus.d_pmem_read = 1'b0;
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0500;
    step();
    chk("t5_new_state", state, SERVE_I);
    chk("t5_new_addr",  bus.pmem_address, 32'h500);
    step();
    bus.pmem_resp = 1'b1; #1;
    chk("t5_new_iresp", bus.i_pmem_resp, 1);
    step();
    bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; #1;
    chk("t5_new_idle", state, IDLE);

    // Stray pmem_resp while IDLE
    step();
    bus.pmem_resp = 1'b1; #1;
    chk("t6_stray_iresp", bus.i_pmem_resp, 0);
    chk("t6_stray_dresp", bus.d_pmem_resp, 0);
    step();
    bus.pmem_resp = 1'b0; #1;
    chk("t6_stray_state", state, IDLE);
    chk("t6_stray_read",  bus.pmem_read, 0);

    // icache drops its request mid-service
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0600;
    step();
    chk("t6_drop_state", state, SERVE_I);
    bus.i_pmem_read = 1'b0;
    step();
    chk("t6_drop_held", bus.pmem_read, 1);
    chk("t6_drop_addr", bus.pmem_address, 32'h600);
    step();
    bus.pmem_resp = 1'b1; #1;
    chk("t6_drop_iresp", bus.i_pmem_resp, 1);
    step();
    bus.pmem_resp = 1'b0; #1;
    chk("t6_drop_iresp_off", bus.i_pmem_resp, 0);
    chk("t6_drop_idle", state, IDLE);
    step();
    chk("t6_drop_once", bus.i_pmem_resp, 0);
    chk("t6_drop_noread", bus.pmem_read, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
